// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                  |
// | Purpose  : FIFO-buffered UART transmitter with parity and stop options.   |
// |            Optional line break generation when UART_TX_BREAK_EN defined. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_UART_RATE       = 1_000_000,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_UART_PARITY     = 0,
  parameter int C_UART_STOP       = 1,
  parameter int C_FIFO_DEPTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [C_UART_DATA_WIDTH-1:0]        data,
  input  logic                                data_valid,
  output logic                                data_ready,
  input  logic                                brk,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                                busy,
  output logic                                tx
);

  localparam int c_BIT_PERIOD = (C_CLK_FRQ + C_UART_RATE / 2) / C_UART_RATE;
  localparam int c_CNT_W      = (c_BIT_PERIOD > 1) ? $clog2(c_BIT_PERIOD) : 1;
  localparam int c_PTR_W      = $clog2(C_FIFO_DEPTH);
  localparam int c_FCNT_W     = $clog2(C_FIFO_DEPTH + 1);
  localparam int c_IDX_W      = 4;

  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(c_BIT_PERIOD - 1);
  localparam logic [c_IDX_W-1:0]  c_DATA_LAST = c_IDX_W'(C_UART_DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0]  c_STOP_LAST = c_IDX_W'(C_UART_STOP - 1);
  localparam logic [c_FCNT_W-1:0] c_FULL      = c_FCNT_W'(C_FIFO_DEPTH);
  localparam logic                c_HAS_PAR   = (C_UART_PARITY != 0);
  localparam logic                c_ODD       = (C_UART_PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
  } state_t;

  // FIFO storage and bookkeeping
  logic [C_UART_DATA_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
  logic [c_PTR_W-1:0]           r_wrPtr;
  logic [c_PTR_W-1:0]           r_rdPtr;
  logic [c_FCNT_W-1:0]          r_count;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_empty;
  logic [C_UART_DATA_WIDTH-1:0] w_popWord;

  // Serializer state
  state_t                       r_state;
  state_t                       w_nState;
  logic [c_CNT_W-1:0]           r_cnt;
  logic [c_CNT_W-1:0]           w_nCnt;
  logic [c_IDX_W-1:0]           r_idx;
  logic [c_IDX_W-1:0]           w_nIdx;
  logic [C_UART_DATA_WIDTH-1:0] r_shift;
  logic [C_UART_DATA_WIDTH-1:0] w_nShift;
  logic                         r_parity;
  logic                         w_nParity;
  logic                         r_tx;
  logic                         w_nTx;
  logic                         w_bitEnd;
  logic                         w_nextFrame;
  logic                         w_brkGo;
  logic                         w_brkReq;

`ifdef UART_TX_BREAK_EN
  assign w_brkReq = brk;
`else
  logic w_unusedBrk;
  assign w_unusedBrk = brk;
  assign w_brkReq    = 1'b0;
`endif

  assign w_empty    = (r_count == '0);
  assign data_ready = (r_count != c_FULL);
  assign w_push     = data_valid & data_ready;
  assign w_popWord  = r_mem[r_rdPtr];
  assign w_bitEnd   = (r_cnt == c_CNT_LAST);

  assign fifo_count = r_count;
  assign busy       = (r_state != ST_IDLE) | (r_count != '0);
  assign tx         = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      end
      r_count <= r_count + c_FCNT_W'(w_push) - c_FCNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_nState;
      r_cnt    <= w_nCnt;
      r_idx    <= w_nIdx;
      r_shift  <= w_nShift;
      r_parity <= w_nParity;
      r_tx     <= w_nTx;
    end
  end

  // tx is computed one step ahead so the line only moves on bit boundaries
  always_comb begin
    w_nState    = r_state;
    w_nCnt      = '0;
    w_nIdx      = r_idx;
    w_nShift    = r_shift;
    w_nParity   = r_parity;
    w_nTx       = r_tx;
    w_pop       = 1'b0;
    w_nextFrame = 1'b0;
    w_brkGo     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nextFrame = 1'b1;
        w_brkGo     = w_brkReq;
      end
      ST_START: begin
        if (w_bitEnd) begin
          w_nState = ST_DATA;
          w_nIdx   = '0;
          w_nTx    = r_shift[0];
          w_nShift = r_shift >> 1;
        end else begin
          w_nCnt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bitEnd) begin
          if (r_idx == c_DATA_LAST) begin
            if (c_HAS_PAR) begin
              w_nState = ST_PARITY;
              w_nTx    = r_parity;
            end else begin
              w_nState = ST_STOP;
              w_nIdx   = '0;
              w_nTx    = 1'b1;
            end
          end else begin
            w_nIdx   = r_idx + c_IDX_W'(1);
            w_nTx    = r_shift[0];
            w_nShift = r_shift >> 1;
          end
        end else begin
          w_nCnt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (w_bitEnd) begin
          w_nState = ST_STOP;
          w_nIdx   = '0;
          w_nTx    = 1'b1;
        end else begin
          w_nCnt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (w_bitEnd) begin
          if (r_idx == c_STOP_LAST) begin
            w_nextFrame = 1'b1;
            w_brkGo     = w_brkReq;
          end else begin
            w_nIdx = r_idx + c_IDX_W'(1);
          end
        end else begin
          w_nCnt = r_cnt + c_CNT_W'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!brk) begin
          w_nState = ST_MARK;
          w_nTx    = 1'b1;
        end
      end
      ST_MARK: begin
        if (w_bitEnd) begin
          w_nextFrame = 1'b1;
        end else begin
          w_nCnt = r_cnt + c_CNT_W'(1);
        end
      end
`endif
      default: begin
        w_nState = ST_IDLE;
        w_nTx    = 1'b1;
      end
    endcase

    // Frame boundary: break takes priority, otherwise launch the next word with no gap
    if (w_nextFrame) begin
      if (w_brkGo) begin
        w_nState = ST_BREAK;
        w_nTx    = 1'b0;
      end else if (!w_empty) begin
        w_pop     = 1'b1;
        w_nState  = ST_START;
        w_nShift  = w_popWord;
        w_nParity = (^w_popWord) ^ c_ODD;
        w_nTx     = 1'b0;
      end else begin
        w_nState = ST_IDLE;
        w_nTx    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: accepts data words through a valid/ready handshake into an internal FIFO and serialises them back-to-back on a single RS232-like line. Supports a configurable word width, parity mode (none/even/odd) and stop bit count, with exact per-bit timing. It sits between the sample/packet producers of the Sigma Delta ADC design and the board serial pin, and replaces the single-word, send-while-not-busy transmitter.

## Interface
- `C_CLK_FRQ`, 100_000_000: input clock frequency [Hz].
- `C_UART_RATE`, 1_000_000: line rate [baud].
- `C_UART_DATA_WIDTH`, 8: data bits per frame, legal 5..9.
- `C_UART_PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `C_UART_STOP`, 1: stop bits, legal 1..2.
- `C_FIFO_DEPTH`, 16: FIFO entries, power of two, ≥ 2.

Ports:
- `clk`  in  1  master clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data`  in  C_UART_DATA_WIDTH  word to transmit.
- `data_valid`  in  1  producer offers `data`.
- `data_ready`  out  1  FIFO can accept a word (= not full).
- `brk`  in  1  break request (active only with `UART_TX_BREAK_EN`).
- `fifo_count`  out  $clog2(C_FIFO_DEPTH+1)  words currently buffered.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `tx`  out  1  serial line, idle high.

## Operation
- Bit period `P = (C_CLK_FRQ + C_UART_RATE/2) / C_UART_RATE` (rounded). Every bit lasts exactly P cycles.
- Frame: start (0), data LSB first, optional parity, C_UART_STOP stop bits (1). Frame length = (1 + W + (PARITY≠0) + STOP) × P cycles.
- Even parity bit = XOR of data bits; odd parity bit = its inverse.
- Write: word is accepted on the edge where `data_valid & data_ready`. `data_ready = !full`. A word offered while full is not accepted and the producer holds it.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus BREAK, MARK when configured).
  - IDLE → START when FIFO non-empty; the word is popped on the same edge.
  - START → DATA after P cycles; DATA → PARITY (or STOP if no parity) after W×P cycles; PARITY → STOP after P.
  - STOP end: if FIFO non-empty → START with a new pop on the same edge (no idle gap), else → IDLE.
- Counters: bit-period counter 0..P-1, bit index 0..W-1 for DATA and 0..STOP-1 for STOP. No wrap beyond the terminal value.
- Simultaneous push and pop: `fifo_count` is unchanged. A push while full is impossible because ready is low.
- `busy = (state ≠ IDLE) | (fifo_count ≠ 0)`.
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `data_ready`=1, state IDLE.
- Reset mid-frame: `tx`=1 at the next edge, the frame is truncated and the FIFO is flushed.

## Timing
- Write accepted at edge N into an empty, idle block: pop and `tx` falls at edge N+1; first data bit at edge N+1+P.
- `tx` is registered and glitch-free; it changes only on bit boundaries.
- `data_ready` and `fifo_count` update at the edge following a push or pop.
- `busy` goes high at edge N when the accepted word lands in the FIFO. It falls at the edge ending the last stop bit when the FIFO is empty.

## Configuration
- `UART_TX_BREAK_EN` defined: `brk` is sampled only in IDLE or at the end of STOP.
  - If `brk`=1 there, the block enters BREAK: `tx`=0 while `brk` stays high, and no FIFO pop occurs.
  - On `brk` falling, the block enters MARK: `tx`=1 for exactly P cycles, then IDLE/START as normal.
  - `busy`=1 during BREAK and MARK.
- Not defined: BREAK and MARK logic is absent and `brk` is ignored (tie low).

## Test plan
- 100 MHz, 1 Mbaud, 8E1: write 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 100 cycles, start edge at N+1, `busy` low after 1100 cycles.
- 8N2 and 7O1: write 0x00 (7O1) → parity bit 1; 8N2 frame is 1100 cycles with 2 stop bits high.
- Burst of 17 back-to-back writes from idle, depth 16 → all 17 accepted, `fifo_count` peaks 16, the 18th waits with `data_ready`=0 until the first frame ends. Frames are contiguous with no idle cycle between stop and start.
- P rounding: C_UART_RATE=115200 → every bit exactly 868 cycles; measure all edges across 4 frames.
- `rst` pulsed mid-DATA of the 2nd of 3 queued words → `tx`=1 next edge, `fifo_count`=0, `busy`=0, no further frames.
- With `UART_TX_BREAK_EN`: `brk` high for 5000 cycles while 1 word is queued → `tx` low 5000 cycles, then high 100 cycles, then the queued frame. Without the macro the same stimulus sends the frame immediately.
